cacheline_mem_arbiter: RTL and testbench

- Shares the single cache-line memory adapter (256-bit line, 64-bit x4 burst behind it) between the I-cache (read-only) and the D-cache (read/write).
- Latches one requester's transaction, drives the adapter request levels until `adapter_resp`, then steers the response back to the owner.
- Sits between the two caches and the adapter. Adds one grant cycle of latency per transaction.

---
 rtl/cacheline_mem_arbiter_pkg.sv | 19 +
 rtl/cacheline_mem_arbiter_watchdog.sv | 52 +++++
 rtl/cacheline_mem_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cacheline_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cache-line memory arbiter: serve-state and operation
// enums plus the line-offset width used to align adapter addresses.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state;

  typedef enum logic {
    ARB_OP_READ  = 1'b0,
    ARB_OP_WRITE = 1'b1
  } arb_op;

  // 256-bit line = 32 bytes, so the low 5 address bits select a byte in a line
  localparam int unsigned LINE_OFFSET_BITS = 5;

endpackage

// File: rtl/cacheline_mem_arbiter_watchdog.sv
// Saturating serve-time watchdog with a sticky timeout flag.
// The flag rises on the clock edge that completes the TIMEOUT_CYCLES-th
// enabled cycle and stays high until reset. TIMEOUT_CYCLES = 0 removes it.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic timeout
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, enable, clear};
      assign timeout = 1'b0;
    end else begin : g_enabled
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] count_reg, count_next;
      logic          flag_reg, flag_next;

      // Count enabled cycles, clear on request, hold at LIMIT instead of wrapping
      always_comb begin
        count_next = count_reg;
        if (clear) begin
          count_next = '0;
        end else if (enable && (count_reg != LIMIT)) begin
          count_next = count_reg + 1'b1;
        end
        flag_next = flag_reg | (count_next == LIMIT);
      end

      // Counter and sticky flag registers
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count_reg <= '0;
          flag_reg  <= 1'b0;
        end else begin
          count_reg <= count_next;
          flag_reg  <= flag_next;
        end
      end

      assign timeout = flag_reg;
    end
  endgenerate

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one cache-line memory adapter between the I-cache and the D-cache.
// A winner is latched in ARB_IDLE; the adapter is then driven only from the
// latched request until adapter_resp, which is steered back to the owner.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate between the caches
// on simultaneous requests instead of fixed D-cache priority.
module cacheline_mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LINE_WIDTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic                  icache_read,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic [ADDR_WIDTH-1:0] adapter_addr,
  output logic                  adapter_read,
  output logic                  adapter_write,
  output logic [LINE_WIDTH-1:0] adapter_wdata,
  input  logic [LINE_WIDTH-1:0] adapter_rdata,
  input  logic                  adapter_resp,
  output logic                  arb_timeout
);

  arb_state              state_reg, state_next;
  arb_op                 op_reg, op_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LINE_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  d_req, i_req, grant_d, grant_i;
  logic                  serving;
  logic                  unused_offset_bits;

  // Byte-offset bits never reach the adapter; the line address is forced aligned
  assign unused_offset_bits = ^{icache_addr[LINE_OFFSET_BITS-1:0],
                                dcache_addr[LINE_OFFSET_BITS-1:0]};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;  // 0 = I-cache granted last, 1 = D-cache

  // Remember who won the most recent grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_reg <= 1'b0;
    end else if (state_reg == ARB_IDLE) begin
      if (grant_d) begin
        last_grant_reg <= 1'b1;
      end else if (grant_i) begin
        last_grant_reg <= 1'b0;
      end
    end
  end
`endif

  // Arbitration: D-cache wins unless round-robin hands a tie to the I-cache
  always_comb begin
    d_req = dcache_read | dcache_write;
    i_req = icache_read;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_d = d_req & (~i_req | ~last_grant_reg);
`else
    grant_d = d_req;
`endif
    grant_i = i_req & ~grant_d;
  end

  // Next state, request latching and all outputs
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    serving       = 1'b0;
    adapter_addr  = '0;
    adapter_read  = 1'b0;
    adapter_write = 1'b0;
    adapter_wdata = '0;
    icache_resp   = 1'b0;
    icache_rdata  = '0;
    dcache_resp   = 1'b0;
    dcache_rdata  = '0;

    case (state_reg)
      ARB_IDLE: begin
        if (grant_d) begin
          state_next = ARB_SERVE_D;
          addr_next  = {dcache_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          op_next    = dcache_write ? ARB_OP_WRITE : ARB_OP_READ;
          if (dcache_write) begin
            wdata_next = dcache_wdata;
          end
        end else if (grant_i) begin
          state_next = ARB_SERVE_I;
          addr_next  = {icache_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
          op_next    = ARB_OP_READ;
        end
      end
      ARB_SERVE_I: begin
        serving = 1'b1;
        if (adapter_resp) begin
          state_next   = ARB_IDLE;
          icache_resp  = 1'b1;
          icache_rdata = adapter_rdata;
        end
      end
      ARB_SERVE_D: begin
        serving = 1'b1;
        if (adapter_resp) begin
          state_next  = ARB_IDLE;
          dcache_resp = 1'b1;
          if (op_reg == ARB_OP_READ) begin
            dcache_rdata = adapter_rdata;
          end
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase

    if (serving) begin
      adapter_addr  = addr_reg;
      adapter_read  = (op_reg == ARB_OP_READ);
      adapter_write = (op_reg == ARB_OP_WRITE);
      if (op_reg == ARB_OP_WRITE) begin
        adapter_wdata = wdata_reg;
      end
    end
  end

  // State and latched-request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ARB_IDLE;
      op_reg    <= ARB_OP_READ;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (state_reg != ARB_IDLE),
    .clear  (state_reg == ARB_IDLE),
    .timeout(arb_timeout)
  );

`ifndef SYNTHESIS
  // Read and write together from the D-cache is illegal; write would win
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(dcache_read && dcache_write));
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Self-checking bench for cacheline_mem_arbiter: a transaction-level model
// (owner, latched line request, serve-cycle count) is compared with every
// DUT output on each falling edge, alongside directed literal checks.
module tb_cacheline_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] icache_addr = '0;
  logic          icache_read = 1'b0;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic [AW-1:0] dcache_addr = '0;
  logic          dcache_read = 1'b0;
  logic          dcache_write = 1'b0;
  logic [LW-1:0] dcache_wdata = '0;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic [AW-1:0] adapter_addr;
  logic          adapter_read;
  logic          adapter_write;
  logic [LW-1:0] adapter_wdata;
  logic [LW-1:0] adapter_rdata = '0;
  logic          adapter_resp = 1'b0;
  logic          arb_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [LW-1:0] LINE_A = {8{32'hA5A5_0001}};
  localparam logic [LW-1:0] LINE_B = {8{32'h1234_5678}};
  localparam logic [LW-1:0] LINE_C = {8{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] WDAT_W = {4{64'h0BAD_F00D_CAFE_0042}};

  cacheline_mem_arbiter #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_read(icache_read),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_addr(dcache_addr), .dcache_read(dcache_read),
    .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .adapter_addr(adapter_addr), .adapter_read(adapter_read),
    .adapter_write(adapter_write), .adapter_wdata(adapter_wdata),
    .adapter_rdata(adapter_rdata), .adapter_resp(adapter_resp),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkl(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit            m_busy = 0, m_owner_d = 0, m_write = 0, m_timeout = 0, m_last_d = 0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  int            m_serve_cnt = 0;
  bit            want_d, want_i, pick_d;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_owner_d = 0; m_write = 0; m_timeout = 0; m_last_d = 0;
      m_addr = '0; m_wdata = '0; m_serve_cnt = 0;
    end else if (m_busy) begin
      m_serve_cnt = m_serve_cnt + 1;
      if (m_serve_cnt >= TO) m_timeout = 1;
      if (adapter_resp) m_busy = 0;
    end else begin
      m_serve_cnt = 0;
      want_d = dcache_read || dcache_write;
      want_i = icache_read;
      pick_d = want_d;
      if (RR && want_d && want_i) pick_d = !m_last_d;
      if (pick_d) begin
        m_busy = 1; m_owner_d = 1; m_write = dcache_write;
        m_addr = dcache_addr & 32'hFFFF_FFE0;
        m_wdata = dcache_write ? dcache_wdata : '0;
        m_last_d = 1;
      end else if (want_i) begin
        m_busy = 1; m_owner_d = 0; m_write = 0;
        m_addr = icache_addr & 32'hFFFF_FFE0;
        m_wdata = '0;
        m_last_d = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic ei, ed;
    ei = m_busy && !m_owner_d && adapter_resp;
    ed = m_busy && m_owner_d && adapter_resp;
    chk1("cyc_adapter_read", adapter_read, m_busy && !m_write);
    chk1("cyc_adapter_write", adapter_write, m_busy && m_write);
    chka("cyc_adapter_addr", adapter_addr, m_busy ? m_addr : '0);
    chkl("cyc_adapter_wdata", adapter_wdata, (m_busy && m_write) ? m_wdata : '0);
    chk1("cyc_icache_resp", icache_resp, ei);
    chkl("cyc_icache_rdata", icache_rdata, ei ? adapter_rdata : '0);
    chk1("cyc_dcache_resp", dcache_resp, ed);
    chkl("cyc_dcache_rdata", dcache_rdata, (ed && !m_write) ? adapter_rdata : '0);
    chk1("cyc_arb_timeout", arb_timeout, m_timeout);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for an adapter request, answer in its lat-th cycle,
  // report which cache saw the response and with what data.
  task automatic respond(input int lat, input logic [LW-1:0] line,
                         output logic got_i, output logic got_d,
                         output logic [LW-1:0] ri, output logic [LW-1:0] rd,
                         output int waited);
    waited = 0;
    while (!(adapter_read || adapter_write) && waited < 40) begin
      tick();
      waited++;
    end
    chk1("req_seen_in_bound", adapter_read || adapter_write, 1'b1);
    repeat (lat - 1) tick();
    adapter_resp  = 1'b1;
    adapter_rdata = line;
    #1;
    got_i = icache_resp; got_d = dcache_resp;
    ri = icache_rdata; rd = dcache_rdata;
    $display("txn: addr=%h op=%s owner=%s wait=%0d", adapter_addr,
             adapter_write ? "write" : "read",
             got_d ? "dcache" : (got_i ? "icache" : "none"), waited);
    tick();
    adapter_resp  = 1'b0;
    adapter_rdata = '0;
  endtask

  initial begin
    #100000;
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic gi, gd;
    logic [LW-1:0] ri, rd;
    int w, pulses;

    // Reset state
    repeat (2) tick();
    chk1("rst_adapter_read", adapter_read, 1'b0);
    chka("rst_adapter_addr", adapter_addr, 32'h0);
    chk1("rst_timeout", arb_timeout, 1'b0);
    rst = 1'b1;
    tick();

    // Simultaneous requests from reset: D-cache first in both builds
    dcache_addr = 32'h0000_2004; dcache_read = 1'b1;
    icache_addr = 32'h0000_3010; icache_read = 1'b1;
    respond(3, LINE_A, gi, gd, ri, rd, w);
    chk1("pairA_first_is_d", gd, 1'b1);
    chk1("pairA_first_not_i", gi, 1'b0);
    chkl("pairA_d_rdata", rd, LINE_A);
    dcache_read = 1'b0;
    chk1("pairA_idle_gap", adapter_read, 1'b0);
    respond(3, LINE_B, gi, gd, ri, rd, w);
    chk1("pairA_second_is_i", gi, 1'b1);
    chk("pairA_i_wait", w);
    chkl("pairA_i_rdata", ri, LINE_B);
    icache_read = 1'b0;

    // D-cache alone, then another simultaneous pair
    dcache_addr = 32'h0000_4000; dcache_read = 1'b1;
    respond(2, LINE_C, gi, gd, ri, rd, w);
    chk1("d_alone_resp", gd, 1'b1);
    dcache_read = 1'b0;
    tick();
    dcache_addr = 32'h0000_4100; dcache_read = 1'b1;
    icache_addr = 32'h0000_4200; icache_read = 1'b1;
    respond(2, LINE_A, gi, gd, ri, rd, w);
    chk1("pairC_first_i", gi, RR);
    chk1("pairC_first_d", gd, !RR);
    if (gi) icache_read = 1'b0; else dcache_read = 1'b0;
    respond(2, LINE_B, gi, gd, ri, rd, w);
    chk1("pairC_second_i", gi, !RR);
    chk1("pairC_second_d", gd, RR);
    icache_read = 1'b0; dcache_read = 1'b0;
    tick();

    // I-cache read 0x1234 alone, line returned in the 6th request cycle
    icache_addr = 32'h0000_1234; icache_read = 1'b1;
    tick();
    chk1("t1_read_at_grant_plus1", adapter_read, 1'b1);
    chka("t1_aligned_addr", adapter_addr, 32'h0000_1220);
    respond(6, LINE_A, gi, gd, ri, rd, w);
    chk1("t1_icache_resp", gi, 1'b1);
    chk1("t1_dcache_quiet", gd, 1'b0);
    chkl("t1_icache_rdata", ri, LINE_A);
    icache_read = 1'b0;
    chk1("t1_level_drops", adapter_read, 1'b0);

    // D-cache write with wdata changing mid-transaction
    dcache_addr = 32'h0000_8040; dcache_wdata = WDAT_W; dcache_write = 1'b1;
    tick();
    chk1("t2_write_level", adapter_write, 1'b1);
    chka("t2_addr", adapter_addr, 32'h0000_8040);
    dcache_wdata = ~WDAT_W;
    tick();
    chkl("t2_wdata_stable1", adapter_wdata, WDAT_W);
    tick();
    chkl("t2_wdata_stable2", adapter_wdata, WDAT_W);
    respond(2, LINE_B, gi, gd, ri, rd, w);
    chk1("t2_dcache_resp", gd, 1'b1);
    chkl("t2_write_rdata_zero", rd, '0);
    dcache_write = 1'b0; dcache_wdata = '0;

    // Stray adapter_resp while idle produces nothing
    adapter_resp = 1'b1; adapter_rdata = LINE_C;
    #1;
    chk1("idle_resp_no_i", icache_resp, 1'b0);
    chk1("idle_resp_no_d", dcache_resp, 1'b0);
    tick();
    adapter_resp = 1'b0; adapter_rdata = '0;
    tick();

    // I-cache holds its request across 3 back-to-back transactions
    icache_addr = 32'h0000_5008; icache_read = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      respond(4, LINE_A ^ LW'(k), gi, gd, ri, rd, w);
      chk("b2b_wait_one", w);
      if (gi) pulses++;
      chk1("b2b_gap_low", adapter_read, 1'b0);
    end
    chk1("b2b_three_pulses", pulses == 3, 1'b1);
    icache_read = 1'b0;
    tick();

    // Watchdog: flag rises on the edge ending the 8th serve cycle
    icache_addr = 32'h0000_6000; icache_read = 1'b1;
    tick();
    for (int c = 1; c <= TO; c++) begin
      chk1("wd_low_before_limit", arb_timeout, 1'b0);
      tick();
    end
    chk1("wd_set_after_limit", arb_timeout, 1'b1);
    tick();
    respond(1, LINE_C, gi, gd, ri, rd, w);
    chk1("wd_late_resp", gi, 1'b1);
    icache_read = 1'b0;
    tick();
    chk1("wd_sticky", arb_timeout, 1'b1);

    // Asynchronous reset in the middle of a D-cache read
    dcache_addr = 32'h0000_7000; dcache_read = 1'b1;
    tick();
    tick();
    chk1("rstmid_serving", adapter_read, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rstmid_read_low", adapter_read, 1'b0);
    chka("rstmid_addr_zero", adapter_addr, 32'h0);
    chk1("rstmid_timeout_clr", arb_timeout, 1'b0);
    dcache_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    icache_addr = 32'h0000_9000; icache_read = 1'b1;
    respond(2, LINE_B, gi, gd, ri, rd, w);
    chk1("post_rst_grant", gi, 1'b1);
    chkl("post_rst_rdata", ri, LINE_B);
    icache_read = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic chk(input string name, input int waited);
    n_checks++;
    if (waited != 1) begin
      n_fail++;
      $display("FAIL %s: got %0d idle cycles expected 1 @%0t", name, waited, $time);
    end
  endtask

endmodule
